// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Issue-side controller for the 8-bit multiplier/divider unit. It accepts one
// arithmetic request at a time and issues it to the unit with a one-cycle
// start pulse. It then waits for the unit's result pulse, or gives up after
// TIMEOUT_CYCLES wait cycles. Finally it writes the result back to the
// register file (quotient and remainder go to two consecutive registers for a
// divide) and records status flags for the CPU.
//
// Parameters
//   TIMEOUT_CYCLES  wait cycles before a timeout is declared (1..255)
//   REG_ADDR_W      register-file address width
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid / req_ready            request handshake (ready only in IDLE)
//   req_multiply, req_a, req_b       operation and operands
//   req_dest                         destination register
//   md_start                         one-cycle start pulse to the unit
//   md_multiply, md_operand_a/b      latched operation and operands
//   md_result, md_remainder          unit results (low result byte is used)
//   md_result_valid                  unit result pulse
//   md_divide_by_zero, md_overflow   unit error flags
//   wb_valid, wb_dest, wb_data       register-file write port
//   done                             one-cycle completion pulse
//   busy                             sequencer not idle
//   flag_overflow/dbz/timeout        status of the last completed operation
//
// Optional feature (macro MULDIV_SEQ_STATS_EN)
//   Adds saturating 16-bit counters stat_ops (every done) and stat_errs
//   (done with any status flag set).
//
// All outputs are registered: each state's actions are computed on the edge
// that enters that state, so an asynchronous reset clears every output
// immediately.
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int REG_ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_multiply,
    input  logic [7:0]            req_a,
    input  logic [7:0]            req_b,
    input  logic [REG_ADDR_W-1:0] req_dest,
    output logic                  md_start,
    output logic                  md_multiply,
    output logic [7:0]            md_operand_a,
    output logic [7:0]            md_operand_b,
    input  logic [15:0]           md_result,
    input  logic [7:0]            md_remainder,
    input  logic                  md_result_valid,
    input  logic                  md_divide_by_zero,
    input  logic                  md_overflow,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic [7:0]            wb_data,
    output logic                  done,
    output logic                  busy,
    output logic                  flag_overflow,
    output logic                  flag_dbz,
    output logic                  flag_timeout
`ifdef MULDIV_SEQ_STATS_EN
    ,
    output logic [15:0]           stat_ops,
    output logic [15:0]           stat_errs
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB_Q,
        S_WB_R
    } state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t                  state_q, state_d;
    logic                    mul_q, mul_d;
    logic [7:0]              opa_q, opa_d;
    logic [7:0]              opb_q, opb_d;
    logic [REG_ADDR_W-1:0]   dest_q, dest_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [7:0]              cnt_inc;
    logic [7:0]              rem_q, rem_d;
    logic                    md_start_q, md_start_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W-1:0]   wb_dest_q, wb_dest_d;
    logic [7:0]              wb_data_q, wb_data_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;
    logic                    f_ovf_q, f_ovf_d;
    logic                    f_dbz_q, f_dbz_d;
    logic                    f_to_q, f_to_d;

    // Only the low result byte is written back.
    logic unused_md_result_hi;
    assign unused_md_result_hi = ^md_result[15:8];

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        mul_d      = mul_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        dest_d     = dest_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        md_start_d = 1'b0;
        wb_valid_d = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;
        done_d     = 1'b0;
        f_ovf_d    = f_ovf_q;
        f_dbz_d    = f_dbz_q;
        f_to_d     = f_to_q;

        case (state_q)
            S_IDLE: begin
                // ready_q gates acceptance so nothing is taken on the very
                // first edge after reset release.
                if (req_valid && ready_q) begin
                    mul_d      = req_multiply;
                    opa_d      = req_a;
                    opb_d      = req_b;
                    dest_d     = req_dest;
                    md_start_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // A result arriving on the timeout cycle still wins.
                if (md_result_valid) begin
                    rem_d = md_remainder;
                    if (md_divide_by_zero) begin
                        f_ovf_d = 1'b0;
                        f_dbz_d = 1'b1;
                        f_to_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_dest_d  = dest_q;
                        wb_data_d  = md_result[7:0];
                        state_d    = S_WB_Q;
                        // A multiply completes in its single write cycle.
                        if (mul_q) begin
                            f_ovf_d = md_overflow;
                            f_dbz_d = 1'b0;
                            f_to_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end else if (cnt_inc == TO_LIMIT) begin
                    f_ovf_d = 1'b0;
                    f_dbz_d = 1'b0;
                    f_to_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WB_Q: begin
                if (mul_q) begin
                    state_d = S_IDLE;
                end else begin
                    // Remainder goes to the next register, wrapping at the top.
                    wb_valid_d = 1'b1;
                    wb_dest_d  = dest_q + REG_ADDR_W'(1);
                    wb_data_d  = rem_q;
                    f_ovf_d    = 1'b0;
                    f_dbz_d    = 1'b0;
                    f_to_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_WB_R;
                end
            end
            S_WB_R: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mul_q      <= 1'b0;
            opa_q      <= 8'd0;
            opb_q      <= 8'd0;
            dest_q     <= '0;
            cnt_q      <= 8'd0;
            rem_q      <= 8'd0;
            md_start_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= 8'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            f_ovf_q    <= 1'b0;
            f_dbz_q    <= 1'b0;
            f_to_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mul_q      <= mul_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            dest_q     <= dest_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            md_start_q <= md_start_d;
            wb_valid_q <= wb_valid_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            f_ovf_q    <= f_ovf_d;
            f_dbz_q    <= f_dbz_d;
            f_to_q     <= f_to_d;
        end
    end

    assign req_ready     = ready_q;
    assign busy          = busy_q;
    assign md_start      = md_start_q;
    assign md_multiply   = mul_q;
    assign md_operand_a  = opa_q;
    assign md_operand_b  = opb_q;
    assign wb_valid      = wb_valid_q;
    assign wb_dest       = wb_dest_q;
    assign wb_data       = wb_data_q;
    assign done          = done_q;
    assign flag_overflow = f_ovf_q;
    assign flag_dbz      = f_dbz_q;
    assign flag_timeout  = f_to_q;

`ifdef MULDIV_SEQ_STATS_EN
    logic [15:0] stat_ops_q;
    logic [15:0] stat_errs_q;

    // Counted while done is visible, using the flags that accompany it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q  <= 16'd0;
            stat_errs_q <= 16'd0;
        end else if (done_q) begin
            if (stat_ops_q != 16'hFFFF) begin
                stat_ops_q <= stat_ops_q + 16'd1;
            end
            if ((f_ovf_q || f_dbz_q || f_to_q) && (stat_errs_q != 16'hFFFF)) begin
                stat_errs_q <= stat_errs_q + 16'd1;
            end
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_errs = stat_errs_q;
`endif

endmodule
